// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI voice allocator: voice count, FSM
// encoding, note/velocity field positions and slot-index helpers.
package midi_pkg;

  localparam int NUM_VOICES = 4;

  // Field positions inside a 14-bit {velocity, note} event word
  localparam int NOTE_LSB = 0;
  localparam int NOTE_MSB = 6;
  localparam int VEL_LSB  = 7;
  localparam int VEL_MSB  = 13;

  localparam logic [6:0] VELOCITY_OFF = 7'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_ISSUE  = 2'd2
  } state_e;

  // Lowest set bit of a 4-slot mask (0 when the mask is empty)
  function automatic logic [1:0] first_set(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  // Slot index to one-hot slot mask
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'd1 << idx;
  endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// Age rank array for the voice slots. Rank 0 is the youngest, rank 3 the
// oldest; ranks always form a permutation of 0..3.
module voice_age_tracker
  import midi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       make_youngest_i,
  input  logic [1:0] make_youngest_idx_i,
  output logic [1:0] oldest_idx_o
);

  logic [1:0] rank_q [NUM_VOICES];
  logic [1:0] rank_d [NUM_VOICES];

  // Touched slot becomes rank 0; slots younger than it age by one
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!make_youngest_i)
        rank_d[i] = rank_q[i];
      else if (2'(i) == make_youngest_idx_i)
        rank_d[i] = 2'd0;
      else if (rank_q[i] < rank_q[make_youngest_idx_i])
        rank_d[i] = rank_q[i] + 2'd1;
      else
        rank_d[i] = rank_q[i];
    end
  end

  // Find the slot holding the oldest rank
  always_comb begin
    oldest_idx_o = 2'd0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (rank_q[i] == 2'd3) oldest_idx_o = 2'(i);
      else                   oldest_idx_o = oldest_idx_o;
    end
  end

  // Rank storage; reset orders slots by index (slot 3 oldest)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) rank_q[i] <= 2'(i);
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) rank_q[i] <= rank_d[i];
    end
  end

endmodule

// File: rtl/midi_voice_allocator.sv
// MIDI voice allocator: maps note events onto four voice slots and
// broadcasts controller changes. Each event walks IDLE -> LOOKUP -> ISSUE,
// so strobes appear two cycles after the event is sampled.
// Optional build macro VOICE_STEAL_EN: a note-on with every slot owned
// steals the oldest slot instead of being dropped.
module midi_voice_allocator #(
  parameter int NUM_VOICES = midi_pkg::NUM_VOICES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  update,
  input  logic                  update_all,
  input  logic [13:0]           note_values,
  input  logic [13:0]           controller_values,
  input  logic [NUM_VOICES-1:0] voice_on_in,
  output logic [NUM_VOICES-1:0] voice_update,
  output logic                  voice_update_all,
  output logic [13:0]           voice_note_values,
  output logic [13:0]           voice_controller_values,
  output logic                  busy,
  output logic                  dropped
);
  import midi_pkg::*;

  localparam logic [1:0] ST_IDLE   = S_IDLE;
  localparam logic [1:0] ST_LOOKUP = S_LOOKUP;
  localparam logic [1:0] ST_ISSUE  = S_ISSUE;

  logic [1:0]            state_q, state_d;
  logic                  busy_q, upd_q, upd_all_q;
  logic [13:0]           note_q, ctrl_q;
  logic [NUM_VOICES-1:0] voice_update_q, voice_update_d;
  logic                  voice_update_all_q, voice_update_all_d;
  logic                  dropped_q, dropped_d;
  logic [NUM_VOICES-1:0] owner_valid_q, owner_valid_d;
  logic [6:0]            owner_note_q [NUM_VOICES];
  logic [6:0]            owner_note_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] voice_on_prev_q;

  logic                  capture_s, clear_all_s, touch_s;
  logic [1:0]            touch_idx_s, oldest_idx_s;
  logic [6:0]            vel_s, key_s;
  logic [NUM_VOICES-1:0] match_s, free_s, set_owner_s, fall_s;

  assign capture_s = (state_q == ST_IDLE) && (update || update_all);
  assign vel_s     = note_q[VEL_MSB:VEL_LSB];
  assign key_s     = note_q[NOTE_MSB:NOTE_LSB];
  assign free_s    = ~owner_valid_q;
  assign fall_s    = voice_on_prev_q & ~voice_on_in;

  // Parallel compare of the event note against every owned slot
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      match_s[i] = owner_valid_q[i] && (owner_note_q[i] == key_s);
    end
  end

  // Sequencing: one event in flight, strobes ignored until back in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (update || update_all) state_d = ST_LOOKUP;
                 else                      state_d = ST_IDLE;
      ST_LOOKUP: state_d = ST_ISSUE;
      ST_ISSUE:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Lookup decision: which slot to strobe and how slot state changes
  always_comb begin
    voice_update_d     = '0;
    voice_update_all_d = 1'b0;
    dropped_d          = 1'b0;
    set_owner_s        = '0;
    clear_all_s        = 1'b0;
    touch_s            = 1'b0;
    touch_idx_s        = 2'd0;
    if (state_q == ST_LOOKUP) begin
      if (upd_all_q) begin
        voice_update_d     = '1;
        voice_update_all_d = 1'b1;
        if (upd_q && (vel_s == VELOCITY_OFF)) clear_all_s = 1'b1;
        else                                  clear_all_s = 1'b0;
      end else if (vel_s == VELOCITY_OFF) begin
        // Note-off keeps ownership until the voice reports it has gone quiet
        if (|match_s) voice_update_d = onehot4(first_set(match_s));
        else          voice_update_d = '0;
      end else if (|match_s) begin
        voice_update_d = onehot4(first_set(match_s));
        touch_s        = 1'b1;
        touch_idx_s    = first_set(match_s);
      end else if (|free_s) begin
        voice_update_d = onehot4(first_set(free_s));
        set_owner_s    = onehot4(first_set(free_s));
        touch_s        = 1'b1;
        touch_idx_s    = first_set(free_s);
      end else begin
`ifdef VOICE_STEAL_EN
        voice_update_d = onehot4(oldest_idx_s);
        set_owner_s    = onehot4(oldest_idx_s);
        touch_s        = 1'b1;
        touch_idx_s    = oldest_idx_s;
`else
        dropped_d      = 1'b1;
`endif
      end
    end else begin
      voice_update_d = '0;
    end
  end

  // Ownership: allocation wins, then release on voice_on falling edge
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      owner_note_d[i] = owner_note_q[i];
      if (clear_all_s) begin
        owner_valid_d[i] = 1'b0;
      end else if (set_owner_s[i]) begin
        owner_valid_d[i] = 1'b1;
        owner_note_d[i]  = key_s;
      end else if (fall_s[i] && !voice_update_q[i]) begin
        owner_valid_d[i] = 1'b0;
      end else begin
        owner_valid_d[i] = owner_valid_q[i];
      end
    end
  end

`ifndef VOICE_STEAL_EN
  logic unused_oldest_s;
  assign unused_oldest_s = ^oldest_idx_s;
`endif

  voice_age_tracker u_age (
    .clk                 (clk),
    .reset               (reset),
    .make_youngest_i     (touch_s),
    .make_youngest_idx_i (touch_idx_s),
    .oldest_idx_o        (oldest_idx_s)
  );

  // State, event capture, slot ownership and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      busy_q             <= 1'b0;
      upd_q              <= 1'b0;
      upd_all_q          <= 1'b0;
      note_q             <= 14'd0;
      ctrl_q             <= 14'd0;
      voice_update_q     <= '0;
      voice_update_all_q <= 1'b0;
      dropped_q          <= 1'b0;
      owner_valid_q      <= '0;
      voice_on_prev_q    <= '0;
      for (int i = 0; i < NUM_VOICES; i++) owner_note_q[i] <= 7'd0;
    end else begin
      state_q            <= state_d;
      busy_q             <= (state_d != ST_IDLE);
      voice_update_q     <= voice_update_d;
      voice_update_all_q <= voice_update_all_d;
      dropped_q          <= dropped_d;
      owner_valid_q      <= owner_valid_d;
      voice_on_prev_q    <= voice_on_in;
      for (int i = 0; i < NUM_VOICES; i++) owner_note_q[i] <= owner_note_d[i];
      if (capture_s) begin
        upd_q     <= update;
        upd_all_q <= update_all;
        note_q    <= note_values;
        ctrl_q    <= controller_values;
      end else begin
        upd_q     <= upd_q;
        upd_all_q <= upd_all_q;
        note_q    <= note_q;
        ctrl_q    <= ctrl_q;
      end
    end
  end

  assign voice_update            = voice_update_q;
  assign voice_update_all        = voice_update_all_q;
  assign voice_note_values       = note_q;
  assign voice_controller_values = ctrl_q;
  assign busy                    = busy_q;
  assign dropped                 = dropped_q;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed, table-driven bench for midi_voice_allocator plus hand-written
// sequences for release/busy-ignore and reset-in-flight.
module tb_midi_voice_allocator;

  logic        clk = 1'b0;
  logic        reset;
  logic        update, update_all;
  logic [13:0] note_values, controller_values;
  logic [3:0]  voice_on_in;
  logic [3:0]  voice_update;
  logic        voice_update_all;
  logic [13:0] voice_note_values, voice_controller_values;
  logic        busy, dropped;

  int n_cmp = 0;
  int n_bad = 0;

  midi_voice_allocator #(.NUM_VOICES(4)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .update                  (update),
    .update_all              (update_all),
    .note_values             (note_values),
    .controller_values       (controller_values),
    .voice_on_in             (voice_on_in),
    .voice_update            (voice_update),
    .voice_update_all        (voice_update_all),
    .voice_note_values       (voice_note_values),
    .voice_controller_values (voice_controller_values),
    .busy                    (busy),
    .dropped                 (dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        upd;
    logic        all;
    logic [13:0] note;
    logic [13:0] ctrl;
    logic [3:0]  exp_vu;
    logic        exp_all;
    logic        exp_drop;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic u, input logic a, input logic [6:0] vel,
                              input logic [6:0] key, input logic [13:0] c,
                              input logic [3:0] evu, input logic eall, input logic edrop);
    vec_t v;
    v.upd = u; v.all = a; v.note = {vel, key}; v.ctrl = c;
    v.exp_vu = evu; v.exp_all = eall; v.exp_drop = edrop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " vu"},   32'(voice_update), 32'd0);
    chk({tag, " vua"},  32'(voice_update_all), 32'd0);
    chk({tag, " vnv"},  32'(voice_note_values), 32'd0);
    chk({tag, " vcv"},  32'(voice_controller_values), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " drop"}, 32'(dropped), 32'd0);
  endtask

  // Drive one event and check N+1, the N+2 strobe cycle, and the return to idle
  task automatic run_event(input string tag, input vec_t v);
    @(negedge clk);
    update = v.upd; update_all = v.all;
    note_values = v.note; controller_values = v.ctrl;
    @(negedge clk);
    update = 1'b0; update_all = 1'b0;
    chk({tag, " busy N+1"}, 32'(busy), 32'd1);
    chk({tag, " early vu"}, 32'(voice_update), 32'd0);
    @(negedge clk);
    chk({tag, " vu"},   32'(voice_update), 32'(v.exp_vu));
    chk({tag, " vua"},  32'(voice_update_all), 32'(v.exp_all));
    chk({tag, " drop"}, 32'(dropped), 32'(v.exp_drop));
    chk({tag, " vnv"},  32'(voice_note_values), 32'(v.note));
    chk({tag, " vcv"},  32'(voice_controller_values), 32'(v.ctrl));
    @(negedge clk);
    chk({tag, " vu after"},   32'(voice_update), 32'd0);
    chk({tag, " drop after"}, 32'(dropped), 32'd0);
    chk({tag, " busy after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; update = 1'b0; update_all = 1'b0;
    note_values = 14'd0; controller_values = 14'd0; voice_on_in = 4'b0000;

    // Slot ages after the first four note-ons and the retrigger of 52:
    // slot0=3 (oldest), slot1=2, slot2=0, slot3=1
    vecs[0]  = mk(1'b1, 1'b0, 7'd127, 7'd29, 14'd0, 4'b0001, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 7'd100, 7'd40, 14'd0, 4'b0010, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 7'd100, 7'd52, 14'd0, 4'b0100, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 7'd100, 7'd64, 14'd0, 4'b1000, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 7'd0,   7'd40, 14'd0, 4'b0010, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 7'd0,   7'd99, 14'd0, 4'b0000, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 7'd90,  7'd52, 14'd0, 4'b0100, 1'b0, 1'b0);
    vecs[7]  = mk(1'b1, 1'b1, 7'd64,  7'd64, {7'h7F, 7'h40}, 4'b1111, 1'b1, 1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 7'd0,   7'd3,  {7'h01, 7'h05}, 4'b1111, 1'b1, 1'b0);
`ifdef VOICE_STEAL_EN
    vecs[9]  = mk(1'b1, 1'b0, 7'd100, 7'd91, 14'd0, 4'b0001, 1'b0, 1'b0);
`else
    vecs[9]  = mk(1'b1, 1'b0, 7'd100, 7'd91, 14'd0, 4'b0000, 1'b0, 1'b1);
`endif
    vecs[10] = mk(1'b1, 1'b1, 7'd0,   7'd0,  {7'h0A, 7'h0B}, 4'b1111, 1'b1, 1'b0);
    vecs[11] = mk(1'b1, 1'b0, 7'd80,  7'd70, 14'd0, 4'b0001, 1'b0, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 7'd80,  7'd71, 14'd0, 4'b0010, 1'b0, 1'b0);
    vecs[13] = mk(1'b1, 1'b0, 7'd0,   7'd70, 14'd0, 4'b0001, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    voice_on_in = 4'b1111;

    for (int i = 0; i < 14; i++) begin
      run_event($sformatf("v%0d", i), vecs[i]);
    end

    // Slot 0 goes quiet after its note-off, so the next note-on reuses it
    // (slot 1 still owned, slot 2 would be next otherwise); a strobe sent
    // while busy must be ignored.
    @(negedge clk);
    voice_on_in = 4'b1110;
    @(negedge clk);
    update = 1'b1; note_values = {7'd80, 7'd72};
    @(negedge clk);
    note_values = {7'd80, 7'd73};
    chk("reuse busy", 32'(busy), 32'd1);
    @(negedge clk);
    update = 1'b0;
    chk("reuse vu", 32'(voice_update), 32'b0001);
    chk("reuse vnv", 32'(voice_note_values), 32'({7'd80, 7'd72}));
    @(negedge clk);
    chk("ignored vu", 32'(voice_update), 32'd0);
    chk("ignored busy", 32'(busy), 32'd0);
    run_event("post-ignore", mk(1'b1, 1'b0, 7'd80, 7'd74, 14'd0, 4'b0100, 1'b0, 1'b0));

    // Reset during LOOKUP aborts the event with no strobe
    @(negedge clk);
    update = 1'b1; note_values = {7'd100, 7'd75}; controller_values = 14'h1234;
    @(negedge clk);
    update = 1'b0;
    chk("abort busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("abort async");
    @(negedge clk);
    check_all_zero("abort next");
    reset = 1'b0;
    @(negedge clk);
    chk("abort no strobe", 32'(voice_update), 32'd0);
    run_event("after reset", mk(1'b1, 1'b0, 7'd127, 7'd29, 14'd0, 4'b0001, 1'b0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
